video_capture: RTL

- Receiver end of the display video bus: consumes hsync, vsync, pixel clock and 4/3/3-bit YCbCr as driven to the display.
- Recovers frame timing, checks it against nominal 858x525 timing and decodes each active pixel back to a 4-bit colour index.
- Writes decoded pixels into a frame buffer as (wr_addr, wr_data, wr_en).
- Used for loopback self-test of the display path and as a verification monitor. All inputs are synchronous to clk; the pixel clock is sampled as data.

---
 rtl/video_pkg.sv | 48 ++++
 rtl/video_capture_if.sv | 29 ++
 rtl/video_capture_ycbcr_decode.sv | 24 ++
 rtl/video_capture.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and nominal timing for the display video bus (capture and display sides).
// Latency: n/a (declarations and one pure function only).
// Backpressure: n/a.
package video_pkg;

  // Nominal timing: pixel periods per line, lines per frame, active window.
  localparam int H_TOTAL  = 858;
  localparam int V_TOTAL  = 525;
  localparam int H_START  = 122;
  localparam int H_ACTIVE = 640;
  localparam int V_START  = 38;
  localparam int V_ACTIVE = 400;

  localparam int ADDR_W = 18;  // holds H_ACTIVE*V_ACTIVE-1 = 255999
  localparam int CNT_W  = 10;  // holds H_TOTAL and V_TOTAL

  typedef enum logic [3:0] {
    BLACK = 4'd0,
    BLUE  = 4'd1,
    RED   = 4'd2,
    GREEN = 4'd3,
    WHITE = 4'd4
  } colour_e;

  typedef struct packed {
    logic [3:0] y;
    logic [2:0] cr;
    logic [2:0] cb;
  } ycbcr_t;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } cap_state_e;

  // CRC-16-CCITT (poly 0x1021), one nibble shifted in MSB first.
  function automatic logic [15:0] crc16_nibble(input logic [15:0] crc, input logic [3:0] nib);
    logic [15:0] c;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      if (c[15] ^ nib[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/video_capture_if.sv
// Display video bus plus frame-buffer write bus seen by the capture block.
// Latency: n/a (wires only).
// Backpressure: none; the video side is free-running and writes are fire-and-forget strobes.
// slave  : capture block (samples video, drives writes)
// master : video source / frame buffer side
interface video_capture_if;
  import video_pkg::*;

  logic              pix_clk_in;
  logic              hsync_in;    // active low
  logic              vsync_in;    // active low
  logic [3:0]        y_in;
  logic [2:0]        cr_in;
  logic [2:0]        cb_in;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic              wr_en;
  logic              frame_done;

  modport slave (
    input  pix_clk_in, hsync_in, vsync_in, y_in, cr_in, cb_in,
    output wr_addr, wr_data, wr_en, frame_done
  );

  modport master (
    output pix_clk_in, hsync_in, vsync_in, y_in, cr_in, cb_in,
    input  wr_addr, wr_data, wr_en, frame_done
  );
endinterface

// File: rtl/video_capture_ycbcr_decode.sv
// Maps a 4/3/3 YCbCr sample to a colour index; unknown codes give BLACK with valid low.
// Latency: combinational.
// Backpressure: n/a.
// Ports: pix (sample in), idx (colour index out), valid (sample matched a table entry).
module ycbcr_decode
  import video_pkg::*;
(
  input  ycbcr_t  pix,
  output colour_e idx,
  output logic    valid
);
  always_comb begin
    idx   = BLACK;
    valid = 1'b1;
    case (pix)
      10'b0001_100_100: idx = BLACK;
      10'b0100_010_111: idx = BLUE;
      10'b0010_110_000: idx = RED;
      10'b0000_000_000: idx = GREEN;
      10'b1001_100_100: idx = WHITE;
      default:          valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/video_capture.sv
// Recovers frame timing from the display bus, locks to nominal timing and writes decoded pixels.
// Latency: 1 clk input register + 1 clk from pixel strobe to wr_en.
// Backpressure: none; writes are strobes and the frame buffer must accept every one.
// Ports: clk, reset_n (async active low); vif.slave (video in, frame-buffer writes out);
//   err_clear (clears sticky flags); locked, sync_err, decode_err status;
//   frame_crc (only when VIDEO_CAPTURE_CRC_EN is defined): CRC-16 of the last frame's wr_data.
module video_capture #(
  parameter int H_TOTAL  = video_pkg::H_TOTAL,
  parameter int V_TOTAL  = video_pkg::V_TOTAL,
  parameter int H_START  = video_pkg::H_START,
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int V_START  = video_pkg::V_START,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE
) (
  input  logic           clk,
  input  logic           reset_n,
  video_capture_if.slave vif,
  input  logic           err_clear,
  output logic           locked,
  output logic           sync_err,
  output logic           decode_err
`ifdef VIDEO_CAPTURE_CRC_EN
  ,
  output logic [15:0]    frame_crc
`endif
);
  import video_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  cap_state_e state_q, state_d;
  logic pix_q, pix_d, pix_prev_q, pix_prev_d, hs_q, hs_d, vs_q, vs_d, clr_q, clr_d;
  logic hs_last_q, hs_last_d, vs_last_q, vs_last_d;
  ycbcr_t px_q, px_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, lcnt_q, lcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [3:0] wr_data_q, wr_data_d;
  logic wr_en_q, wr_en_d, frame_done_q, frame_done_d;
  logic sync_err_q, sync_err_d, decode_err_q, decode_err_d;
`ifdef VIDEO_CAPTURE_CRC_EN
  logic [15:0] crc_run_q, crc_run_d, frame_crc_q, frame_crc_d, crc_next;
`endif

  logic strobe, hs_fall, vs_fall, active, chk_fail, do_wr, dec_valid;
  logic [CNT_W-1:0] pix_idx, line_idx;
  colour_e dec_idx;

  ycbcr_decode u_decode (.pix(px_q), .idx(dec_idx), .valid(dec_valid));

  // Next state: SEARCH waits for a frame start, TRAIN needs one clean frame, LOCKED writes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (vs_fall) state_d = TRAIN;
      TRAIN:   if (chk_fail) state_d = SEARCH; else if (vs_fall) state_d = LOCKED;
      LOCKED:  if (chk_fail) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    pix_d = vif.pix_clk_in;  pix_prev_d = pix_q;
    hs_d  = vif.hsync_in;    vs_d = vif.vsync_in;  clr_d = err_clear;
    px_d  = {vif.y_in, vif.cr_in, vif.cb_in};
    hs_last_d = hs_last_q;  vs_last_d = vs_last_q;
    pcnt_d = pcnt_q;  lcnt_d = lcnt_q;  addr_d = addr_q;
    wr_addr_d = wr_addr_q;  wr_data_d = wr_data_q;

    strobe  = pix_q & ~pix_prev_q;
    // Sync edges compare the levels seen at consecutive strobes, not consecutive clocks.
    hs_fall = strobe & hs_last_q & ~hs_q;
    vs_fall = strobe & vs_last_q & ~vs_q;

    // Position of the pixel carried by this strobe.
    pix_idx  = hs_fall ? '0 : pcnt_q + 1'b1;
    line_idx = hs_fall ? (vs_fall ? '0 : lcnt_q + 1'b1) : lcnt_q;
    active   = (pix_idx  >= CNT_W'(H_START)) && (pix_idx  < CNT_W'(H_START + H_ACTIVE)) &&
               (line_idx >= CNT_W'(V_START)) && (line_idx < CNT_W'(V_START + V_ACTIVE));

    // The counters still hold the last index of the ending line/frame at the falling edge.
    chk_fail = (state_q != SEARCH) &&
               ((hs_fall && (pcnt_q != CNT_W'(H_TOTAL - 1))) ||
                (vs_fall && (lcnt_q != CNT_W'(V_TOTAL - 1))));

    do_wr        = strobe & (state_q == LOCKED) & active;
    wr_en_d      = do_wr;
    frame_done_d = do_wr & (addr_q == LAST_ADDR);

    if (strobe) begin
      hs_last_d = hs_q;
      vs_last_d = vs_q;
      pcnt_d    = pix_idx;
      lcnt_d    = line_idx;
    end
    if (do_wr) begin
      wr_addr_d = addr_q;
      wr_data_d = dec_idx;
      addr_d    = addr_q + 1'b1;
    end
    if (vs_fall) addr_d = '0;

    // A new error in the same cycle as a clear leaves the flag set.
    sync_err_d   = chk_fail ? 1'b1 : (clr_q ? 1'b0 : sync_err_q);
    decode_err_d = (do_wr && !dec_valid) ? 1'b1 : (clr_q ? 1'b0 : decode_err_q);

`ifdef VIDEO_CAPTURE_CRC_EN
    crc_run_d   = crc_run_q;
    frame_crc_d = frame_crc_q;
    crc_next    = crc16_nibble(crc_run_q, dec_idx);
    if (vs_fall) crc_run_d = 16'hFFFF;
    if (do_wr) begin
      crc_run_d = crc_next;
      if (addr_q == LAST_ADDR) frame_crc_d = crc_next;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEARCH;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= 1'b0;  pix_prev_q <= 1'b0;  hs_q <= 1'b0;  vs_q <= 1'b0;  clr_q <= 1'b0;
      hs_last_q <= 1'b0;  vs_last_q <= 1'b0;  px_q <= '0;
      pcnt_q <= '0;  lcnt_q <= '0;  addr_q <= '0;
      wr_addr_q <= '0;  wr_data_q <= '0;  wr_en_q <= 1'b0;  frame_done_q <= 1'b0;
      sync_err_q <= 1'b0;  decode_err_q <= 1'b0;
`ifdef VIDEO_CAPTURE_CRC_EN
      crc_run_q <= 16'hFFFF;  frame_crc_q <= '0;
`endif
    end else begin
      pix_q <= pix_d;  pix_prev_q <= pix_prev_d;  hs_q <= hs_d;  vs_q <= vs_d;  clr_q <= clr_d;
      hs_last_q <= hs_last_d;  vs_last_q <= vs_last_d;  px_q <= px_d;
      pcnt_q <= pcnt_d;  lcnt_q <= lcnt_d;  addr_q <= addr_d;
      wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;  wr_en_q <= wr_en_d;
      frame_done_q <= frame_done_d;
      sync_err_q <= sync_err_d;  decode_err_q <= decode_err_d;
`ifdef VIDEO_CAPTURE_CRC_EN
      crc_run_q <= crc_run_d;  frame_crc_q <= frame_crc_d;
`endif
    end
  end

  assign vif.wr_addr    = wr_addr_q;
  assign vif.wr_data    = wr_data_q;
  assign vif.wr_en      = wr_en_q;
  assign vif.frame_done = frame_done_q;
  assign locked         = (state_q == LOCKED);
  assign sync_err       = sync_err_q;
  assign decode_err     = decode_err_q;
`ifdef VIDEO_CAPTURE_CRC_EN
  assign frame_crc      = frame_crc_q;
`endif

endmodule
